// File: rtl/yin_pkg.sv
// Shared types for the pitch/tone path: fixed-point format, waveform select
// and synthesizer FSM states.
package yin_pkg;

  localparam int FRAC_BITS = 16;

  typedef enum logic [1:0] {
    WAVE_SQUARE = 2'd0,
    WAVE_SAW    = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_SILENT = 2'd3
  } wave_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } synth_state_e;

endpackage

// File: rtl/wave_shaper.sv
// Registered phase-to-sample stage: maps the top phase bits to a signed
// square/saw/triangle sample with one cycle of latency.
module wave_shaper
  import yin_pkg::*;
#(
  parameter int SIG_WIDTH = 9
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic [SIG_WIDTH:0]          phase_top_in,
  input  logic [1:0]                  wave_sel_in,
  input  logic                        mute_in,
  input  logic                        valid_in,
  output logic signed [SIG_WIDTH-1:0] sig_out,
  output logic                        sig_out_valid
);

  localparam logic [SIG_WIDTH-1:0] AMP_POS = {1'b0, {(SIG_WIDTH-1){1'b1}}};
  localparam logic [SIG_WIDTH-1:0] AMP_NEG = {1'b1, {(SIG_WIDTH-2){1'b0}}, 1'b1};
  localparam logic [SIG_WIDTH-1:0] ZERO    = {SIG_WIDTH{1'b0}};

  // Offset-binary to two's complement: flipping the msb recentres 0..2^N-1 on zero.
  function automatic logic [SIG_WIDTH-1:0] offset_flip(input logic [SIG_WIDTH-1:0] x);
    return {~x[SIG_WIDTH-1], x[SIG_WIDTH-2:0]};
  endfunction

  logic                 half_s;
  logic [SIG_WIDTH-1:0] p_s;
  logic [SIG_WIDTH-1:0] q_s;
  logic [SIG_WIDTH-1:0] sample_d, sample_q;
  logic                 valid_d, valid_q;

  assign half_s = phase_top_in[SIG_WIDTH];
  assign p_s    = phase_top_in[SIG_WIDTH:1];
  assign q_s    = phase_top_in[SIG_WIDTH-1:0];

  always_comb begin
    sample_d = sample_q;
    valid_d  = 1'b0;
    if (valid_in) begin
      valid_d = 1'b1;
      if (mute_in) begin
        sample_d = ZERO;
      end else begin
        case (wave_e'(wave_sel_in))
          WAVE_SQUARE: sample_d = half_s ? AMP_NEG : AMP_POS;
          WAVE_SAW:    sample_d = offset_flip(p_s);
          WAVE_TRI:    sample_d = half_s ? ~offset_flip(q_s) : offset_flip(q_s);
          WAVE_SILENT: sample_d = ZERO;
          default:     sample_d = ZERO;
        endcase
      end
    end else begin
      sample_d = sample_q;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sample_q <= ZERO;
      valid_q  <= 1'b0;
    end else begin
      sample_q <= sample_d;
      valid_q  <= valid_d;
    end
  end

  assign sig_out       = sample_q;
  assign sig_out_valid = valid_q;

endmodule

// File: rtl/tone_synth.sv
// DDS tone synthesizer: Q16.16 Hz word in, signed sample stream out at SAMPLE_RATE.
// Holds the sample-tick divider, load FSM, clamp/multiply pipeline and phase accumulator.
module tone_synth
  import yin_pkg::*;
#(
  parameter int SIG_WIDTH   = 9,
  parameter int WIDTH       = 32,
  parameter int PHASE_W     = 24,
  parameter int SAMPLE_RATE = 8000,
  parameter int CLK_FREQ    = 100_000_000
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic [WIDTH-1:0]            f_in,
  input  logic                        f_in_valid,
  output logic                        f_in_ready,
  input  logic [1:0]                  wave_sel,
  output logic signed [SIG_WIDTH-1:0] sig_out,
  output logic                        sig_out_valid
);

  localparam int CLK_DIV = CLK_FREQ / SAMPLE_RATE;
  localparam int CNT_W   = $clog2(CLK_DIV);
  localparam int PROD_W  = WIDTH + 32;

  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   F_NYQ      = WIDTH'(64'(SAMPLE_RATE / 2) << FRAC_BITS);
  localparam logic [WIDTH-1:0]   F_ZERO     = {WIDTH{1'b0}};
  localparam logic [63:0]        INC_SCALE  = ((64'd1 << (PHASE_W + FRAC_BITS))
                                               + 64'(SAMPLE_RATE / 2)) / 64'(SAMPLE_RATE);
  localparam logic [PROD_W-1:0]  SCALE_EXT  = PROD_W'(INC_SCALE);
  localparam logic [PROD_W-1:0]  ROUND_HALF = {{(PROD_W-32){1'b0}}, 32'h8000_0000};
  localparam logic [PHASE_W-1:0] INC_CAP    = {1'b1, {(PHASE_W-1){1'b0}}};
  localparam logic [PROD_W-1:0]  INC_CAP_EX = {{(PROD_W-PHASE_W){1'b0}}, INC_CAP};
  localparam logic [PHASE_W-1:0] PHASE_ZERO = {PHASE_W{1'b0}};
  localparam logic [PROD_W-1:0]  PROD_ZERO  = {PROD_W{1'b0}};

  synth_state_e       state_d, state_q;
  logic               load_c2_d, load_c2_q;
  logic [WIDTH-1:0]   f_d, f_q;
  logic [PROD_W-1:0]  prod_d, prod_q;
  logic [PHASE_W-1:0] inc_d, inc_q;
  logic [PHASE_W-1:0] phase_d, phase_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q;
  logic               ready_d, ready_q;

  logic               tick_s;
  logic               accept_s;
  logic               f_nonzero_s;
  logic [WIDTH-1:0]   f_clamp_s;
  logic [PROD_W-1:0]  f_ext_s;
  logic [PROD_W-1:0]  inc_round_s;
  logic [PHASE_W-1:0] inc_new_s;

  assign tick_s      = (cnt_q == CNT_LAST);
  assign accept_s    = f_in_valid && ready_q;
  assign f_nonzero_s = (f_in != F_ZERO);
  assign f_clamp_s   = (f_q > F_NYQ) ? F_NYQ : f_q;
  assign f_ext_s     = {{(PROD_W-WIDTH){1'b0}}, f_clamp_s};
  assign inc_round_s = (prod_q + ROUND_HALF) >> 32;
  assign inc_new_s   = (inc_round_s > INC_CAP_EX) ? INC_CAP : inc_round_s[PHASE_W-1:0];

  always_comb begin
    state_d   = state_q;
    load_c2_d = load_c2_q;
    f_d       = f_q;
    prod_d    = prod_q;
    inc_d     = inc_q;
    cnt_d     = tick_s ? CNT_ZERO : (cnt_q + CNT_ONE);
    // The tick always advances with the inc in force before this edge.
    phase_d   = tick_s ? (phase_q + inc_q) : phase_q;
    case (state_q)
      IDLE: begin
        phase_d = PHASE_ZERO;
        if (accept_s && f_nonzero_s) begin
          state_d   = LOAD;
          load_c2_d = 1'b0;
          f_d       = f_in;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (!load_c2_q) begin
          prod_d    = f_ext_s * SCALE_EXT;
          load_c2_d = 1'b1;
        end else begin
          inc_d     = inc_new_s;
          load_c2_d = 1'b0;
          if (inc_new_s == PHASE_ZERO) begin
            state_d = IDLE;
            phase_d = PHASE_ZERO;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (accept_s) begin
          state_d   = LOAD;
          load_c2_d = 1'b0;
          f_d       = f_in;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d   = IDLE;
        load_c2_d = 1'b0;
        phase_d   = PHASE_ZERO;
        inc_d     = PHASE_ZERO;
      end
    endcase
    ready_d = (state_d != LOAD);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      load_c2_q <= 1'b0;
      f_q       <= F_ZERO;
      prod_q    <= PROD_ZERO;
      inc_q     <= PHASE_ZERO;
      phase_q   <= PHASE_ZERO;
      cnt_q     <= CNT_ZERO;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      load_c2_q <= load_c2_d;
      f_q       <= f_d;
      prod_q    <= prod_d;
      inc_q     <= inc_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
    end
  end

  assign f_in_ready = ready_q;

  wave_shaper #(
    .SIG_WIDTH(SIG_WIDTH)
  ) u_shaper (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .phase_top_in (phase_q[PHASE_W-1 -: SIG_WIDTH+1]),
    .wave_sel_in  (wave_sel),
    .mute_in      (state_q == IDLE),
    .valid_in     (tick_s),
    .sig_out      (sig_out),
    .sig_out_valid(sig_out_valid)
  );

endmodule

// File: tb/tb_tone_synth.sv
// Bench for tone_synth at CLK_DIV=100: table of known tones, hand sequences for
// retune-to-zero and reset, and random traffic against a cycle-stepped reference model.
module tb_tone_synth;

  localparam int CLK_DIV = 100;
  localparam longint unsigned SCALE = ((64'd1 << 40) + 64'd4000) / 64'd8000;
  localparam longint unsigned NYQ   = 64'd4000 << 16;
  localparam longint unsigned CAP   = 64'd1 << 23;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic [31:0]       f_in;
  logic              f_in_valid;
  logic              f_in_ready;
  logic [1:0]        wave_sel;
  logic signed [8:0] sig_out;
  logic              sig_out_valid;

  tone_synth #(
    .SIG_WIDTH(9), .WIDTH(32), .PHASE_W(24), .SAMPLE_RATE(8000), .CLK_FREQ(800_000)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .f_in(f_in), .f_in_valid(f_in_valid),
    .f_in_ready(f_in_ready), .wave_sel(wave_sel), .sig_out(sig_out),
    .sig_out_valid(sig_out_valid)
  );

  always #5 clk_in = ~clk_in;

  int n_pass = 0;
  int n_total = 0;

  // Reference model state: sample clock position, phase, increment, pending retune.
  int              m_cnt;
  longint unsigned m_phase, m_inc, m_pend;
  bit              m_idle, m_ready, m_exp_valid;
  int              m_left, m_exp_sig;

  typedef struct packed {
    logic [31:0]     f;
    logic [1:0]      sel;
    logic [7:0][8:0] exp;
  } vec_t;
  vec_t vecs [5];

  function automatic logic [7:0][8:0] pack8(input int a0, a1, a2, a3, a4, a5, a6, a7);
    logic [7:0][8:0] r;
    r[0] = 9'(a0); r[1] = 9'(a1); r[2] = 9'(a2); r[3] = 9'(a3);
    r[4] = 9'(a4); r[5] = 9'(a5); r[6] = 9'(a6); r[7] = 9'(a7);
    return r;
  endfunction

  function automatic longint unsigned inc_ref(input logic [31:0] f);
    longint unsigned fc, r;
    fc = (longint'(f) > NYQ) ? NYQ : longint'(f);
    r  = (fc * SCALE + 64'd2147483648) >> 32;
    return (r > CAP) ? CAP : r;
  endfunction

  function automatic int wave_ref(input logic [1:0] sel, input longint unsigned ph);
    int p, q, t;
    bit upper;
    upper = (ph >= CAP);
    p = int'(ph >> 15);
    q = int'((ph >> 14) & 64'd511);
    t = q - 256;
    case (sel)
      2'd0:    return upper ? -255 : 255;
      2'd1:    return p - 256;
      2'd2:    return upper ? (-t - 1) : t;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // One clock: advance the model from the inputs now applied, then compare.
  task automatic step();
    bit tick, acc;
    if (rst_in) begin
      m_cnt = 0; m_phase = 0; m_inc = 0; m_pend = 0; m_idle = 1'b1;
      m_left = 0; m_ready = 1'b1; m_exp_valid = 1'b0; m_exp_sig = 0;
    end else begin
      tick = (m_cnt == CLK_DIV - 1);
      acc  = f_in_valid && m_ready;
      m_cnt = tick ? 0 : m_cnt + 1;
      m_exp_valid = tick;
      if (tick) begin
        m_exp_sig = m_idle ? 0 : wave_ref(wave_sel, m_phase);
        m_phase   = (m_phase + m_inc) & 64'hFF_FFFF;
      end
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_inc = m_pend;
          if (m_pend == 0) begin
            m_idle  = 1'b1;
            m_phase = 0;
          end
        end
      end else if (acc && !(m_idle && f_in == 32'd0)) begin
        m_pend = inc_ref(f_in);
        m_left = 2;
        m_idle = 1'b0;
      end
      m_ready = (m_left == 0);
    end
    @(posedge clk_in);
    #1;
    chk("model_ready", f_in_ready, m_ready);
    chk("model_valid", sig_out_valid, m_exp_valid);
    chk("model_sample", sig_out, m_exp_sig);
  endtask

  task automatic do_reset(input int n);
    rst_in = 1'b1;
    repeat (n) step();
    rst_in = 1'b0;
    chk("reset_sig", sig_out, 0);
    chk("reset_valid", sig_out_valid, 0);
    chk("reset_ready", f_in_ready, 1);
  endtask

  // Steps until a strobe appears (bounded); returns cycles taken.
  task automatic wait_strobe(output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (!sig_out_valid && cycles < 250);
    chk("strobe_seen", sig_out_valid, 1);
  endtask

  task automatic send(input logic [31:0] f, input int hold);
    f_in = f;
    f_in_valid = 1'b1;
    repeat (hold) step();
    f_in_valid = 1'b0;
  endtask

  task automatic check_first_strobes();
    int c;
    wait_strobe(c);
    chk("first_strobe_cycle", c, CLK_DIV);
    chk("first_strobe_zero", sig_out, 0);
    wait_strobe(c);
    chk("strobe_period", c, CLK_DIV);
    chk("idle_sample_zero", sig_out, 0);
  endtask

  initial begin
    int c, r;
    rst_in = 1'b1; f_in = 32'd0; f_in_valid = 1'b0; wave_sel = 2'd0;

    vecs[0] = '{f: 32'h01B8_0000, sel: 2'd1,
                exp: pack8(-256, -228, -200, -172, -144, -116, -88, -59)};
    vecs[1] = '{f: 32'h03E8_0000, sel: 2'd0,
                exp: pack8(255, 255, 255, 255, -255, -255, -255, -255)};
    vecs[2] = '{f: 32'h03E8_0000, sel: 2'd2,
                exp: pack8(-256, -128, 0, 128, 255, 127, -1, -129)};
    vecs[3] = '{f: 32'h2000_0000, sel: 2'd0,
                exp: pack8(255, -255, 255, -255, 255, -255, 255, -255)};
    vecs[4] = '{f: 32'hFFFF_FFFF, sel: 2'd1,
                exp: pack8(-256, 0, -256, 0, -256, 0, -256, 0)};

    do_reset(5);
    check_first_strobes();

    for (int i = 0; i < 5; i++) begin
      do_reset(5);
      wave_sel = vecs[i].sel;
      send(vecs[i].f, 1);
      chk("load_ready_low1", f_in_ready, 0);
      step();
      chk("load_ready_low2", f_in_ready, 0);
      step();
      chk("load_ready_back", f_in_ready, 1);
      for (int k = 0; k < 8; k++) begin
        wait_strobe(c);
        chk("vec_sample", sig_out, $signed(vecs[i].exp[k]));
      end
    end

    // Retune to zero from RUN: one accept, IDLE after two cycles, silent output.
    do_reset(5);
    wave_sel = 2'd0;
    send(32'h03E8_0000, 1);
    repeat (3) wait_strobe(c);
    f_in = 32'd0;
    f_in_valid = 1'b1;
    step();
    chk("zero_ready_low1", f_in_ready, 0);
    step();
    chk("zero_ready_low2", f_in_ready, 0);
    step();
    chk("zero_ready_idle", f_in_ready, 1);
    f_in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_strobe(c);
      chk("zero_silent", sig_out, 0);
    end

    // Reset in the middle of RUN restarts the sample clock from scratch.
    send(32'h03E8_0000, 1);
    repeat (2) wait_strobe(c);
    repeat (37) step();
    do_reset(5);
    check_first_strobes();

    // Random traffic against the reference model.
    for (int n = 0; n < 6000; n++) begin
      rst_in = ($urandom_range(0, 2999) == 0);
      if (!(f_in_valid && $urandom_range(0, 2) != 0)) begin
        f_in_valid = ($urandom_range(0, 149) == 0);
        r = $urandom_range(0, 4);
        case (r)
          0:       f_in = 32'd0;
          1:       f_in = 32'hFFFF_FFFF;
          2:       f_in = (32'($urandom_range(1, 4000)) << 16) | 32'($urandom_range(0, 65535));
          3:       f_in = $urandom();
          default: f_in = 32'($urandom_range(0, 1000));
        endcase
      end
      if ($urandom_range(0, 99) == 0) wave_sel = 2'($urandom_range(0, 3));
      step();
    end
    rst_in = 1'b0;
    f_in_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
